// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg
//   Shared definitions for the bus-controlled JTAG initiator: operation codes,
//   register offsets, the VERSION constant, FSM state encoding and the fixed
//   TMS walk patterns used to move the TAP between Run-Test/Idle and the
//   Shift states. Patterns are stored LSB-first: bit k is the TMS value for
//   the k-th TCK pulse of that phase.
package jtag_master_pkg;

  localparam logic [7:0] VERSION = 8'd1;

  typedef enum logic [1:0] {
    OP_DR   = 2'd0,
    OP_IR   = 2'd1,
    OP_TLR  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_SUFFIX = 2'd3
  } state_e;

  // Register offsets relative to BASEADDR.
  localparam int unsigned REG_VERSION = 0;
  localparam int unsigned REG_START   = 1;
  localparam int unsigned REG_OP      = 2;
  localparam int unsigned REG_LEN_LO  = 3;
  localparam int unsigned REG_LEN_HI  = 4;
  localparam int unsigned REG_DIV     = 5;
  localparam int unsigned REG_CTRL    = 6;
  localparam int unsigned MEM_OFFSET  = 16;

  // RTI -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [7:0] DR_PREFIX_TMS = 8'b0000_0001;
  localparam logic [2:0] DR_PREFIX_LEN = 3'd3;
  // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [7:0] IR_PREFIX_TMS = 8'b0000_0011;
  localparam logic [2:0] IR_PREFIX_LEN = 3'd4;
  // Five TMS=1 reach Test-Logic-Reset from any state, then one 0 to RTI.
  localparam logic [7:0] TLR_TMS       = 8'b0001_1111;
  localparam logic [2:0] TLR_LEN       = 3'd6;
  // Exit1 -> Update -> RTI
  localparam logic [7:0] SUFFIX_TMS    = 8'b0000_0001;
  localparam logic [2:0] SUFFIX_LEN    = 3'd2;

  function automatic logic [7:0] prefix_tms(input op_e op);
    case (op)
      OP_DR:   return DR_PREFIX_TMS;
      OP_IR:   return IR_PREFIX_TMS;
      default: return TLR_TMS;
    endcase
  endfunction

  function automatic logic [2:0] prefix_len(input op_e op);
    case (op)
      OP_DR:   return DR_PREFIX_LEN;
      OP_IR:   return IR_PREFIX_LEN;
      default: return TLR_LEN;
    endcase
  endfunction

endpackage

// File: rtl/jtag_master_core.sv
// jtag_master_core
//   TCK divider, scan FSM, bit counters, TDO synchronizer and the buffer
//   access ports of the JTAG initiator.
// Ports:
//   clk_i, srst_i          clock, synchronous active-high reset (bus or soft)
//   start_i                one-cycle START request (qualified here)
//   op_i, len_i, div_i     operation, bit count, TCK divider
//   tdo_i                  raw TDO from the TAP (asynchronous)
//   tck_o,tms_o,tdi_o      registered JTAG outputs
//   busy_o                 high while an operation runs
//   tdi_rd_addr_o/_data_i  TDI buffer read port (one cycle latency)
//   tdo_we_o/_waddr_o/_wdata_o  TDO buffer byte write port
module jtag_master_core
  import jtag_master_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int AW        = 5
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [15:0]   len_i,
  input  logic [7:0]    div_i,
  input  logic          tdo_i,
  output logic          tck_o,
  output logic          tms_o,
  output logic          tdi_o,
  output logic          busy_o,
  output logic [AW-1:0] tdi_rd_addr_o,
  input  logic [7:0]    tdi_rd_data_i,
  output logic          tdo_we_o,
  output logic [AW-1:0] tdo_waddr_o,
  output logic [7:0]    tdo_wdata_o
);

  localparam int            LW      = $clog2(MEM_BYTES * 8 + 1);
  localparam int            IW      = AW + 3;
  localparam logic [LW-1:0] MAX_LEN = LW'(MEM_BYTES * 8);

  state_e        state_q;
  op_e           op_q;
  logic [LW-1:0] len_q;
  logic [7:0]    div_q;
  logic [7:0]    div_cnt_q;
  logic [LW-1:0] bit_cnt_q;
  logic [IW-1:0] tdi_idx_q;
  logic [IW-1:0] cap_idx_q;
  logic [7:0]    acc_q;
  logic          tck_q, tms_q, tdi_q, busy_q;
  logic          rise_q;
  logic          tdo_meta_q, tdo_sync_q;

  op_e           op_in;
  logic [LW-1:0] len_eff;
  logic [7:0]    div_eff;
  logic          start_ok;
  logic [7:0]    pfx_in, pfx_q;

  state_e        state_d;
  logic [LW-1:0] cnt_d;
  logic          tms_d, tdi_d;
  logic [7:0]    acc_d;

  assign op_in    = op_e'(op_i);
  assign len_eff  = (len_i > 16'(MAX_LEN)) ? MAX_LEN : LW'(len_i);
  assign div_eff  = (div_i == 8'd0) ? 8'd1 : div_i;
  assign start_ok = start_i && (state_q == ST_IDLE) && (op_in != OP_RSVD) &&
                    ((op_in == OP_TLR) || (len_i != 16'd0));
  assign pfx_in   = prefix_tms(op_in);
  assign pfx_q    = prefix_tms(op_q);

  // Where the walk goes at the end of the current bit's high phase, and what
  // TMS/TDI that next bit carries.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_cnt_q + LW'(1);
    case (state_q)
      ST_PREFIX: begin
        if (bit_cnt_q == LW'(prefix_len(op_q)) - LW'(1)) begin
          cnt_d   = '0;
          state_d = (op_q == OP_TLR) ? ST_IDLE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == len_q - LW'(1)) begin
          cnt_d   = '0;
          state_d = ST_SUFFIX;
        end
      end
      ST_SUFFIX: begin
        if (bit_cnt_q == LW'(SUFFIX_LEN) - LW'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: cnt_d = '0;
    endcase

    tms_d = tms_q;  // parked TMS value is harmless while TCK is stopped
    tdi_d = 1'b0;
    case (state_d)
      ST_PREFIX: tms_d = pfx_q[cnt_d[2:0]];
      ST_SHIFT: begin
        tms_d = (cnt_d == len_q - LW'(1));  // last bit moves to Exit1
        tdi_d = tdi_rd_data_i[tdi_idx_q[2:0]];
      end
      ST_SUFFIX: tms_d = SUFFIX_TMS[cnt_d[2:0]];
      default: ;
    endcase
  end

  // The whole partially-filled byte is rewritten on every sample so an abort
  // leaves every captured bit in the buffer; not-yet-sampled bits read as 0.
  always_comb begin
    acc_d                 = acc_q;
    acc_d[cap_idx_q[2:0]] = tdo_sync_q;
  end

  // Sampling one cycle into the high phase gives the 2-flop synchronizer time
  // to see a TDO that changed at the falling edge, even with the minimum
  // two-cycle low phase.
  assign tdo_we_o      = rise_q && (state_q == ST_SHIFT);
  assign tdo_waddr_o   = cap_idx_q[IW-1:3];
  assign tdo_wdata_o   = acc_d;
  assign tdi_rd_addr_o = tdi_idx_q[IW-1:3];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      tdo_meta_q <= 1'b0;
      tdo_sync_q <= 1'b0;
    end else begin
      tdo_meta_q <= tdo_i;
      tdo_sync_q <= tdo_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_DR;
      len_q     <= '0;
      div_q     <= 8'd1;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= '0;
      tdi_idx_q <= '0;
      cap_idx_q <= '0;
      acc_q     <= 8'd0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (tdo_we_o) begin
        cap_idx_q <= cap_idx_q + IW'(1);
        acc_q     <= (cap_idx_q[2:0] == 3'd7) ? 8'd0 : acc_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q   <= ST_PREFIX;
            op_q      <= op_in;
            len_q     <= len_eff;
            div_q     <= div_eff;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= '0;
            tdi_idx_q <= '0;
            cap_idx_q <= '0;
            acc_q     <= 8'd0;
            tck_q     <= 1'b0;
            tms_q     <= pfx_in[0];
            tdi_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          if (div_cnt_q == div_q) begin
            div_cnt_q <= 8'd0;
            if (!tck_q) begin
              tck_q  <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              tck_q     <= 1'b0;
              state_q   <= state_d;
              bit_cnt_q <= cnt_d;
              tms_q     <= tms_d;
              tdi_q     <= tdi_d;
              if (state_d == ST_SHIFT) tdi_idx_q <= tdi_idx_q + IW'(1);
              if (state_d == ST_IDLE)  busy_q    <= 1'b0;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign tck_o  = tck_q;
  assign tms_o  = tms_q;
  assign tdi_o  = tdi_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/jtag_master.sv
// jtag_master
//   8-bit BUS_* peripheral wrapping jtag_master_core: bus decode, control
//   registers, and the TDI (write-only from bus) and TDO (read-only from bus)
//   byte buffers.
// Ports:
//   BUS_CLK, BUS_RST     clock and synchronous active-high reset
//   BUS_ADD/DATA/RD/WR   peripheral bus; reads return data one cycle later
//   JTAG_TCK/TMS/TDI     registered TAP drive, JTAG_TDO raw TAP return
//   JTAG_TRST            CTRL bit0 level
//   BUSY                 operation in progress
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter logic [31:0] BASEADDR  = 32'h0000_0000,
  parameter logic [31:0] HIGHADDR  = 32'h0000_0000,
  parameter int          ABUSWIDTH = 32,
  parameter int          MEM_BYTES = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic                 JTAG_TCK,
  output logic                 JTAG_TMS,
  output logic                 JTAG_TDI,
  input  logic                 JTAG_TDO,
  output logic                 JTAG_TRST,
  output logic                 BUSY
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  localparam logic [ABUSWIDTH-1:0] A_BASE    = ABUSWIDTH'(BASEADDR);
  localparam logic [ABUSWIDTH-1:0] A_HIGH    = ABUSWIDTH'(HIGHADDR);
  localparam logic [ABUSWIDTH-1:0] A_VERSION = ABUSWIDTH'(REG_VERSION);
  localparam logic [ABUSWIDTH-1:0] A_START   = ABUSWIDTH'(REG_START);
  localparam logic [ABUSWIDTH-1:0] A_OP      = ABUSWIDTH'(REG_OP);
  localparam logic [ABUSWIDTH-1:0] A_LEN_LO  = ABUSWIDTH'(REG_LEN_LO);
  localparam logic [ABUSWIDTH-1:0] A_LEN_HI  = ABUSWIDTH'(REG_LEN_HI);
  localparam logic [ABUSWIDTH-1:0] A_DIV     = ABUSWIDTH'(REG_DIV);
  localparam logic [ABUSWIDTH-1:0] A_CTRL    = ABUSWIDTH'(REG_CTRL);
  localparam logic [ABUSWIDTH-1:0] A_MEM     = ABUSWIDTH'(MEM_OFFSET);
  localparam logic [ABUSWIDTH-1:0] A_MEM_END = ABUSWIDTH'(MEM_OFFSET + MEM_BYTES);

  logic [ABUSWIDTH-1:0] off;
  logic                 in_range, wr_en, rd_en, mem_hit;
  logic [AW-1:0]        mem_idx;
  logic                 soft_rst, core_rst, start;
  logic                 busy;

  logic [1:0]  op_q;
  logic [15:0] len_q;
  logic [7:0]  div_q;
  logic        ctrl_q;

  logic [7:0]  reg_rd;
  logic        rd_valid_q, rd_mem_q;
  logic [7:0]  rd_reg_q, tdo_rd_q, tdi_rd_q;

  logic [7:0]  tdi_mem [MEM_BYTES];
  logic [7:0]  tdo_mem [MEM_BYTES];

  logic [AW-1:0] tdi_rd_addr, tdo_waddr;
  logic          tdo_we;
  logic [7:0]    tdo_wdata;

  assign off      = BUS_ADD - A_BASE;
  assign in_range = (BUS_ADD >= A_BASE) && (BUS_ADD <= A_HIGH);
  assign wr_en    = BUS_WR && in_range;
  assign rd_en    = BUS_RD && in_range;
  assign mem_hit  = (off >= A_MEM) && (off < A_MEM_END);
  assign mem_idx  = AW'(off - A_MEM);
  assign soft_rst = wr_en && (off == A_VERSION);
  assign core_rst = BUS_RST || soft_rst;
  assign start    = wr_en && (off == A_START);

  // Scan parameters are frozen while busy; CTRL stays live so TRST can be
  // driven at any time.
  always_ff @(posedge BUS_CLK) begin
    if (core_rst) begin
      op_q   <= 2'd0;
      len_q  <= 16'd0;
      div_q  <= 8'd1;
      ctrl_q <= 1'b0;
    end else if (wr_en) begin
      if (off == A_CTRL) ctrl_q <= BUS_DATA[0];
      if (!busy) begin
        case (off)
          A_OP:     op_q         <= BUS_DATA[1:0];
          A_LEN_LO: len_q[7:0]   <= BUS_DATA;
          A_LEN_HI: len_q[15:8]  <= BUS_DATA;
          A_DIV:    div_q        <= BUS_DATA;
          default:  ;
        endcase
      end
    end
  end

  // Buffers are never cleared by reset so partial capture data survives aborts.
  always_ff @(posedge BUS_CLK) begin
    if (wr_en && mem_hit && !busy) tdi_mem[mem_idx] <= BUS_DATA;
    tdi_rd_q <= tdi_mem[tdi_rd_addr];
  end

  always_ff @(posedge BUS_CLK) begin
    if (tdo_we) tdo_mem[tdo_waddr] <= tdo_wdata;
    tdo_rd_q <= tdo_mem[mem_idx];
  end

  always_comb begin
    reg_rd = 8'h00;
    case (off)
      A_VERSION: reg_rd = VERSION;
      A_START:   reg_rd = {7'd0, ~busy};
      A_OP:      reg_rd = {6'd0, op_q};
      A_LEN_LO:  reg_rd = len_q[7:0];
      A_LEN_HI:  reg_rd = len_q[15:8];
      A_DIV:     reg_rd = div_q;
      A_CTRL:    reg_rd = {7'd0, ctrl_q};
      default:   reg_rd = 8'h00;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      rd_valid_q <= 1'b0;
      rd_mem_q   <= 1'b0;
      rd_reg_q   <= 8'h00;
    end else begin
      rd_valid_q <= rd_en;
      rd_mem_q   <= mem_hit;
      rd_reg_q   <= reg_rd;
    end
  end

  assign BUS_DATA = rd_valid_q ? (rd_mem_q ? tdo_rd_q : rd_reg_q) : 8'hzz;

  jtag_master_core #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_core (
    .clk_i         (BUS_CLK),
    .srst_i        (core_rst),
    .start_i       (start),
    .op_i          (op_q),
    .len_i         (len_q),
    .div_i         (div_q),
    .tdo_i         (JTAG_TDO),
    .tck_o         (JTAG_TCK),
    .tms_o         (JTAG_TMS),
    .tdi_o         (JTAG_TDI),
    .busy_o        (busy),
    .tdi_rd_addr_o (tdi_rd_addr),
    .tdi_rd_data_i (tdi_rd_q),
    .tdo_we_o      (tdo_we),
    .tdo_waddr_o   (tdo_waddr),
    .tdo_wdata_o   (tdo_wdata)
  );

  assign JTAG_TRST = ctrl_q;
  assign BUSY      = busy;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master
//   Directed bench for jtag_master: drives bus transactions, records TCK
//   pulses with their TMS/TDI values, and compares against hand-computed
//   expectations. TDO can be looped back to TDI.
`timescale 1ns/1ps
module tb_jtag_master;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic [31:0] BUS_ADD = 32'd0;
  wire  [7:0]  BUS_DATA;
  logic        BUS_RD  = 1'b0;
  logic        BUS_WR  = 1'b0;
  logic        JTAG_TCK, JTAG_TMS, JTAG_TDI, JTAG_TRST, BUSY;
  wire         JTAG_TDO;

  logic        loopback = 1'b0;
  logic [7:0]  wdata    = 8'h00;
  logic        drive    = 1'b0;

  assign BUS_DATA = drive ? wdata : 8'hzz;
  assign JTAG_TDO = loopback ? JTAG_TDI : 1'b0;

  always #5 BUS_CLK = ~BUS_CLK;

  jtag_master #(
    .BASEADDR  (32'h0000_0000),
    .HIGHADDR  (32'd47),
    .ABUSWIDTH (32),
    .MEM_BYTES (32)
  ) dut (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST   (BUS_RST),
    .BUS_ADD   (BUS_ADD),
    .BUS_DATA  (BUS_DATA),
    .BUS_RD    (BUS_RD),
    .BUS_WR    (BUS_WR),
    .JTAG_TCK  (JTAG_TCK),
    .JTAG_TMS  (JTAG_TMS),
    .JTAG_TDI  (JTAG_TDI),
    .JTAG_TDO  (JTAG_TDO),
    .JTAG_TRST (JTAG_TRST),
    .BUSY      (BUSY)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Pulse monitor, sampled on the falling BUS_CLK edge.
  int   pulse_cnt = 0;
  int   busy_cyc  = 0;
  int   high_cyc  = 0;
  logic tck_prev  = 1'b0;
  logic tms_log [2048];
  logic tdi_log [2048];

  always @(negedge BUS_CLK) begin
    if (BUSY) busy_cyc <= busy_cyc + 1;
    if (JTAG_TCK) high_cyc <= high_cyc + 1;
    if (JTAG_TCK && !tck_prev) begin
      tms_log[pulse_cnt[10:0]] <= JTAG_TMS;
      tdi_log[pulse_cnt[10:0]] <= JTAG_TDI;
      pulse_cnt <= pulse_cnt + 1;
    end
    tck_prev <= JTAG_TCK;
  end

  int          p0, b0, h0;
  int          np, nb, nh;
  logic [63:0] tv, dv;

  task automatic bus_wr(input int a, input logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = 32'(a);
    wdata   = d;
    drive   = 1'b1;
    BUS_WR  = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR  = 1'b0;
    drive   = 1'b0;
  endtask

  task automatic bus_rd(input int a, output logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = 32'(a);
    BUS_RD  = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD  = 1'b0;
    d       = BUS_DATA;
  endtask

  task automatic snap;
    @(posedge BUS_CLK);
    #1;
    p0 = pulse_cnt;
    b0 = busy_cyc;
    h0 = high_cyc;
  endtask

  task automatic finish_scan(input string tag);
    int n;
    n = 0;
    while (BUSY && n < 5000) begin
      @(negedge BUS_CLK);
      n++;
    end
    chk({tag, "_done"}, {63'd0, BUSY}, 64'd0);
    repeat (2) @(posedge BUS_CLK);
    #1;
    np = pulse_cnt - p0;
    nb = busy_cyc - b0;
    nh = high_cyc - h0;
    tv = '0;
    dv = '0;
    for (int k = 0; k < np && k < 64; k++) begin
      tv[k] = tms_log[(p0 + k) % 2048];
      dv[k] = tdi_log[(p0 + k) % 2048];
    end
  endtask

  task automatic run_scan(input string tag);
    snap();
    bus_wr(1, 8'h00);
    finish_scan(tag);
  endtask

  initial begin
    logic [7:0] rd;
    int         n;

    repeat (3) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);

    // Reset state
    chk("rst_tck",  {63'd0, JTAG_TCK},  64'd0);
    chk("rst_tms",  {63'd0, JTAG_TMS},  64'd1);
    chk("rst_tdi",  {63'd0, JTAG_TDI},  64'd0);
    chk("rst_trst", {63'd0, JTAG_TRST}, 64'd0);
    chk("rst_busy", {63'd0, BUSY},      64'd0);
    bus_rd(0, rd); chk("version",  64'(rd), 64'd1);
    bus_rd(1, rd); chk("ready",    64'(rd), 64'd1);
    bus_rd(5, rd); chk("div_rst",  64'(rd), 64'd1);
    bus_rd(3, rd); chk("len_rst",  64'(rd), 64'd0);
    bus_rd(8, rd); chk("undef_rd", 64'(rd), 64'd0);

    // DR scan, loopback
    loopback = 1'b1;
    bus_wr(5, 8'd1); bus_wr(2, 8'd0); bus_wr(3, 8'd8); bus_wr(4, 8'd0);
    bus_wr(16, 8'hA5);
    run_scan("dr");
    chk("dr_pulses", 64'(np), 64'd13);
    chk("dr_tms",    tv, 64'h0C01);
    chk("dr_tdi",    dv, 64'h528);
    chk("dr_busy",   64'(nb), 64'd52);
    bus_rd(16, rd); chk("dr_tdo", 64'(rd), 64'hA5);

    // IR scan
    bus_wr(2, 8'd1); bus_wr(3, 8'd5); bus_wr(16, 8'h13);
    run_scan("ir");
    chk("ir_pulses", 64'(np), 64'd11);
    chk("ir_tms",    tv, 64'h303);
    chk("ir_tdi",    dv, 64'h130);
    chk("ir_busy",   64'(nb), 64'd44);
    bus_rd(16, rd); chk("ir_tdo", 64'(rd), 64'h13);

    // TLR
    bus_wr(2, 8'd2);
    run_scan("tlr");
    chk("tlr_pulses", 64'(np), 64'd6);
    chk("tlr_tms",    tv, 64'h1F);
    chk("tlr_tdi",    dv, 64'h0);
    bus_rd(1, rd); chk("tlr_ready", 64'(rd), 64'd1);

    // Divider: DIV=0 -> 4-cycle period, DIV=3 -> 8-cycle period, 4 high
    bus_wr(5, 8'd0);
    run_scan("div0");
    chk("div0_busy", 64'(nb), 64'd24);
    chk("div0_high", 64'(nh), 64'd12);
    bus_wr(5, 8'd3);
    run_scan("div3");
    chk("div3_pulses", 64'(np), 64'd6);
    chk("div3_busy",   64'(nb), 64'd48);
    chk("div3_high",   64'(nh), 64'd24);

    // Accesses during BUSY are ignored
    bus_wr(5, 8'd1); bus_wr(2, 8'd0); bus_wr(3, 8'd8); bus_wr(16, 8'hA5);
    snap();
    bus_wr(1, 8'h00);
    bus_wr(1, 8'h00);
    bus_wr(16, 8'h00);
    bus_wr(3, 8'd1);
    finish_scan("busy_ign");
    chk("busy_start_pulses", 64'(np), 64'd13);
    chk("busy_start_cycles", 64'(nb), 64'd52);
    run_scan("busy_ign2");
    chk("busy_len_pulses", 64'(np), 64'd13);
    bus_rd(16, rd); chk("busy_tdi_kept", 64'(rd), 64'hA5);

    // LEN=0 with DR: never busy
    bus_wr(3, 8'd0);
    snap();
    bus_wr(1, 8'h00);
    repeat (10) @(negedge BUS_CLK);
    finish_scan("len0");
    chk("len0_busy",   64'(nb), 64'd0);
    chk("len0_pulses", 64'(np), 64'd0);

    // OP=3 is ignored
    bus_wr(3, 8'd8); bus_wr(2, 8'd3);
    snap();
    bus_wr(1, 8'h00);
    repeat (10) @(negedge BUS_CLK);
    finish_scan("op3");
    chk("op3_busy", 64'(nb), 64'd0);

    // LEN clamp: 300 -> 256
    bus_wr(2, 8'd0); bus_wr(3, 8'h2C); bus_wr(4, 8'h01);
    run_scan("clamp");
    chk("clamp_pulses", 64'(np), 64'd261);
    chk("clamp_busy",   64'(nb), 64'd1044);

    // TRST follows CTRL
    bus_wr(6, 8'h01);
    chk("trst_set", {63'd0, JTAG_TRST}, 64'd1);

    // Abort mid-SHIFT via soft reset
    bus_wr(3, 8'd16); bus_wr(4, 8'd0);
    snap();
    bus_wr(1, 8'h00);
    n = 0;
    while ((pulse_cnt - p0) < 6 && n < 1000) begin
      @(negedge BUS_CLK);
      n++;
    end
    chk("abort_in_shift", {63'd0, BUSY}, 64'd1);
    bus_wr(0, 8'h00);
    chk("abort_tck",  {63'd0, JTAG_TCK},  64'd0);
    chk("abort_tms",  {63'd0, JTAG_TMS},  64'd1);
    chk("abort_busy", {63'd0, BUSY},      64'd0);
    chk("abort_trst", {63'd0, JTAG_TRST}, 64'd0);
    bus_rd(3, rd); chk("abort_len", 64'(rd), 64'd0);
    bus_rd(5, rd); chk("abort_div", 64'(rd), 64'd1);
    bus_wr(2, 8'd2);
    run_scan("post_abort_tlr");
    chk("post_abort_pulses", 64'(np), 64'd6);
    chk("post_abort_tms",    tv, 64'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
Bus-controlled JTAG initiator that drives a TAP, such as the emulated DCD TAP on the probe card, from a host UART/bus transaction. The host loads TDI bits, the length and the operation, then writes START. The block walks the TAP from Run-Test/Idle to Shift-IR or Shift-DR, shifts N bits while capturing TDO, and returns to Run-Test/Idle. It sits on the standard 8-bit BUS_* peripheral bus next to the gpio, pulse_gen and seq_gen blocks.

Parameters:
BASEADDR, 32'h0000_0000, first bus address of the block.
HIGHADDR, 32'h0000_0000, last bus address of the block.
ABUSWIDTH, 32, width of BUS_ADD.
MEM_BYTES, 32, depth in bytes of each of the TDI buffer and the TDO buffer; maximum length is MEM_BYTES*8 bits.

Ports:
BUS_CLK  in  1  single clock for all logic.
BUS_RST  in  1  synchronous, active-high reset.
BUS_ADD  in  ABUSWIDTH  bus address.
BUS_DATA  inout  8  bus data.
BUS_RD  in  1  read strobe.
BUS_WR  in  1  write strobe.
JTAG_TCK  out  1  test clock; idles low.
JTAG_TMS  out  1  test mode select.
JTAG_TDI  out  1  serial data to the TAP.
JTAG_TDO  in  1  serial data from the TAP; asynchronous to BUS_CLK.
JTAG_TRST  out  1  level taken from the CTRL register.
BUSY  out  1  high while an operation runs.

Behaviour:
- Register map, as offsets from BASEADDR:
  - 0: write any value = soft reset; read returns VERSION = 1.
  - 1: write any value = START; read returns bit0 READY (= ~BUSY).
  - 2: OP[1:0]. 0 = DR scan, 1 = IR scan, 2 = TLR (test-logic reset), 3 = reserved, ignored like 2'b11 NOP.
  - 3: LEN[7:0]. 4: LEN[15:8]. LEN is the bit count.
  - 5: DIV[7:0] (TCK divider).
  - 6: CTRL. bit0 = JTAG_TRST level.
  - 16 to 16+MEM_BYTES-1: a write loads the TDI buffer byte; a read returns the TDO buffer byte.
- Bit order: bit0 of byte0 is shifted first.
- Bus reads: data is registered and driven on BUS_DATA in the BUS_CLK cycle after BUS_RD with an in-range address. BUS_DATA is high-Z otherwise. Reads of undefined offsets return 0.
- Reset values (BUS_RST or soft reset):
  - outputs: TCK=0, TMS=1, TDI=0, TRST=0, BUSY=0.
  - registers: OP=0, LEN=0, DIV=1.
  - buffers are not cleared.
- TCK timing:
  - Effective divider D = max(DIV,1).
  - Each TCK bit = low phase of D+1 cycles followed by high phase of D+1 cycles.
  - TMS/TDI update in the first cycle of the low phase (the falling edge).
- TDO capture:
  - JTAG_TDO passes through a 2-flop synchronizer.
  - The synchronized value is sampled in the cycle TCK rises, during Shift-state bits only.
  - Sample i is written to TDO buffer bit i.
- State machine: IDLE -> PREFIX -> SHIFT -> SUFFIX -> IDLE. TLR uses PREFIX only.
  - DR prefix TMS: 1,0,0.
  - IR prefix TMS: 1,1,0,0.
  - SHIFT: N bits; TMS=0 for bits 0..N-2 and TMS=1 on bit N-1 (Exit1).
  - SUFFIX TMS: 1,0 (Update, Run-Test/Idle).
  - TLR TMS: 1,1,1,1,1,0.
  - TDI = 0 outside SHIFT.
- Total TCK pulses: DR = N+5, IR = N+6, TLR = 6.
- BUSY timing: BUSY rises the cycle after the START write and falls the cycle after the last high phase ends (TCK back to 0).
- START boundary conditions:
  - START while BUSY: ignored.
  - START with OP=3: ignored.
  - START with DR/IR and LEN=0: ignored; BUSY stays 0.
  - LEN > MEM_BYTES*8: clamped to MEM_BYTES*8.
- While BUSY, writes to the TDI buffer, OP, LEN and DIV are ignored. CTRL and soft reset remain writable.
- Soft reset or BUS_RST mid-operation: the operation aborts immediately, outputs take their reset values, and the TDO buffer keeps partial data. The TAP state is then undefined, and the host must issue TLR.
- TCK, TMS, TDI and TRST are registered outputs.

Decomposition:
- Package jtag_master_pkg holds:
  - the OP codes;
  - the register offsets;
  - the VERSION constant;
  - the prefix/suffix TMS patterns and their lengths.
- Sub-module jtag_master_core holds the TCK divider, the FSM, the bit counter, the TDO synchronizer and the buffer read/write ports.
- The top level keeps the bus decode, the registers and the two MEM_BYTES buffers.

Test Plan:
- DR scan with loopback:
  - Stimulus: DIV=1, OP=0, LEN=8, TDI byte0=0xA5, JTAG_TDO tied to JTAG_TDI, START.
  - Expected TMS per TCK: 1,0,0,0,0,0,0,0,0,0,1,1,0 (13 pulses).
  - Expected BUSY: high for 52 cycles.
  - Expected TDO buffer: byte0 reads 0xA5.
- IR scan: OP=1, LEN=5, TDI=0x13 -> 11 TCK pulses; TDI during shift is 1,1,0,0,1; TMS is 1,1,0,0,0,0,0,0,1,1,0.
- TLR: OP=2, START -> 6 pulses with TMS 1,1,1,1,1,0; TDI stays 0; READY reads 1 afterwards.
- Divider: DIV=0 gives 4-cycle TCK periods; DIV=3 gives 8-cycle periods with a 4/4 duty.
- Ignored accesses:
  - START during BUSY: no effect on pulse count.
  - TDI write during BUSY: no effect on that buffer byte.
  - LEN=0 with DR, then START: BUSY never rises.
- Abort: soft-reset write mid-SHIFT -> next cycle TCK=0, TMS=1 and BUSY=0; a following TLR completes normally.
